// File: rtl/matmul_pkg.sv
// ----------------------------------------------------------------------------
// matmul_pkg
//   Shared types and constants for the matmul sequencer and its tag pipeline.
//   - DATA_WIDTH / MAX_DIM and the widths derived from them.
//   - element_t, dim_t, idx_t scalar typedefs.
//   - err_e: completion error code reported with done.
//   - state_e plus ST_* constants for the sequencer FSM.
//   - tag_t: per-issue bookkeeping carried alongside the operand read.
//   - check_dims(): dimension validation in priority order.
// ----------------------------------------------------------------------------
package matmul_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int MAX_DIM    = 256;
    localparam int DIM_W      = $clog2(MAX_DIM + 1);
    localparam int IDX_W      = $clog2(MAX_DIM);

    typedef logic [DATA_WIDTH-1:0] element_t;
    typedef logic [DIM_W-1:0]      dim_t;
    typedef logic [IDX_W-1:0]      idx_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ZERO     = 2'd1,
        ERR_OVERSIZE = 2'd2,
        ERR_MISMATCH = 2'd3
    } err_e;

    typedef logic [2:0] state_e;
    localparam state_e ST_IDLE  = 3'd0;
    localparam state_e ST_CHECK = 3'd1;
    localparam state_e ST_ISSUE = 3'd2;
    localparam state_e ST_DRAIN = 3'd3;
    localparam state_e ST_FIN   = 3'd4;

    typedef struct packed {
        logic first;   // p == 0: MAC loads instead of accumulating
        logic last;    // p == m-1: final term of this dot product
        idx_t row;     // i
        idx_t col;     // c
    } tag_t;

    // Zero-size beats oversize, which beats an inner-dimension mismatch.
    function automatic err_e check_dims(dim_t n, dim_t m, dim_t j, dim_t k);
        if (n == '0 || m == '0 || j == '0 || k == '0)
            return ERR_ZERO;
        if (n > dim_t'(MAX_DIM) || m > dim_t'(MAX_DIM) ||
            j > dim_t'(MAX_DIM) || k > dim_t'(MAX_DIM))
            return ERR_OVERSIZE;
        if (m != j)
            return ERR_MISMATCH;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/matmul_tag_pipe.sv
// ----------------------------------------------------------------------------
// matmul_tag_pipe
//   DEPTH-stage delay line that carries a valid bit and a tag_t alongside the
//   operand-memory read, so the tag emerges in the cycle the data does.
//   Ports:
//     clk, reset     clock, asynchronous active-low reset
//     flush          synchronous clear of every valid bit
//     in_valid/tag   entry issued this cycle
//     out_valid/tag  entry issued DEPTH cycles ago
//     any_valid      some entry still in flight
// ----------------------------------------------------------------------------
module matmul_tag_pipe
    import matmul_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    input  tag_t in_tag,
    output logic out_valid,
    output tag_t out_tag,
    output logic any_valid
);

    logic [DEPTH-1:0] vld;
    tag_t             tags [DEPTH];

    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // old value, so loop order inside the block does not matter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int s = 1; s < DEPTH; s++)
                vld[s] <= vld[s-1];
        end
    end

    // NOTE: the tag payload is deliberately left unreset; nothing looks at it
    // unless the matching valid bit is set, and the valid bits are reset.
    always_ff @(posedge clk) begin
        tags[0] <= in_tag;
        for (int s = 1; s < DEPTH; s++)
            tags[s] <= tags[s-1];
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tags[DEPTH-1];
    assign any_valid = |vld;

endmodule

// File: rtl/matmul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// matmul_seq_ctrl
//   Sequencer for the matmul datapath. Accepts an (n x m) * (j x k) job,
//   validates the dimensions, walks i/c/p (p innermost) issuing operand reads,
//   drives MAC load/accumulate control RD_LAT cycles later, emits one result
//   write per dot product and finishes with a done pulse and an error code.
//   Dimension widths (MAX_DIM, DIM_W, IDX_W) come from matmul_pkg.
//   Ports:
//     clk, reset                      clock, asynchronous active-low reset
//     start, dim_n/m/j/k              job request and dimensions (IDLE only)
//     hold                            pause new issues; in-flight ops drain
//     abort                           synchronous cancel, no done
//     busy                            job in progress
//     rd_en, a_row/a_col, b_row/b_col operand reads A[i][p], B[p][c]
//     mac_en, mac_first, mac_last     MAC operand valid / load / final term
//     c_wr_en, c_row, c_col           result write strobe and address
//     done, err                       completion pulse and error code
// ----------------------------------------------------------------------------
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_j,
    input  logic [DIM_W-1:0] dim_k,
    input  logic             hold,
    input  logic             abort,
    output logic             busy,
    output logic             rd_en,
    output logic [IDX_W-1:0] a_row,
    output logic [IDX_W-1:0] a_col,
    output logic [IDX_W-1:0] b_row,
    output logic [IDX_W-1:0] b_col,
    output logic             mac_en,
    output logic             mac_first,
    output logic             mac_last,
    output logic             c_wr_en,
    output logic [IDX_W-1:0] c_row,
    output logic [IDX_W-1:0] c_col,
    output logic             done,
    output logic [1:0]       err
);

    state_e state_q, state_d;
    dim_t   n_q, m_q, j_q, k_q;
    idx_t   i_q, c_q, p_q;
    err_e   err_q, chk_err;

    // Loop bounds; only meaningful once CHECK has proven every dim >= 1.
    idx_t n_last, m_last, k_last;
    assign n_last = idx_t'(n_q - dim_t'(1));
    assign m_last = idx_t'(m_q - dim_t'(1));
    assign k_last = idx_t'(k_q - dim_t'(1));

    logic p_wrap, c_wrap, i_wrap, issue_done;
    assign p_wrap     = (p_q == m_last);
    assign c_wrap     = (c_q == k_last);
    assign i_wrap     = (i_q == n_last);
    assign issue_done = rd_en && p_wrap && c_wrap && i_wrap;

    assign chk_err = check_dims(n_q, m_q, j_q, k_q);

    // Issue pipeline
    tag_t issue_tag, mac_tag;
    logic mac_vld, any_vld;

    assign issue_tag.first = (p_q == '0);
    assign issue_tag.last  = p_wrap;
    assign issue_tag.row   = i_q;
    assign issue_tag.col   = c_q;

    matmul_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .in_valid  (rd_en),
        .in_tag    (issue_tag),
        .out_valid (mac_vld),
        .out_tag   (mac_tag),
        .any_valid (any_vld)
    );

    // Next-state logic; abort overrides every other transition.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHECK;
            ST_CHECK: state_d = (chk_err != ERR_NONE) ? ST_FIN : ST_ISSUE;
            ST_ISSUE: if (issue_done) state_d = ST_DRAIN;
            // Once the last tag leaves the pipe its write strobe is already
            // registered, so an empty pipe means every result is out.
            ST_DRAIN: if (!any_vld) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            m_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            i_q     <= '0;
            c_q     <= '0;
            p_q     <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;

            if (state_q == ST_IDLE && start) begin
                n_q <= dim_n;
                m_q <= dim_m;
                j_q <= dim_j;
                k_q <= dim_k;
            end

            // err holds from FIN until the next accepted start clears it.
            if (state_q == ST_IDLE && start && !abort)
                err_q <= ERR_NONE;
            else if (state_q == ST_CHECK && !abort)
                err_q <= chk_err;

            if (state_q == ST_CHECK) begin
                i_q <= '0;
                c_q <= '0;
                p_q <= '0;
            end else if (rd_en) begin
                if (!p_wrap) begin
                    p_q <= p_q + idx_t'(1);
                end else begin
                    p_q <= '0;
                    if (!c_wrap) begin
                        c_q <= c_q + idx_t'(1);
                    end else begin
                        c_q <= '0;
                        if (!i_wrap) i_q <= i_q + idx_t'(1);
                    end
                end
            end
        end
    end

    // Result write stage: one cycle behind the final MAC term.
    logic c_wr_q;
    idx_t c_row_q, c_col_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_wr_q  <= 1'b0;
            c_row_q <= '0;
            c_col_q <= '0;
        end else begin
            c_wr_q <= mac_en && mac_last && !abort;
            if (mac_en && mac_last) begin
                c_row_q <= mac_tag.row;
                c_col_q <= mac_tag.col;
            end
        end
    end

    // Address and tag outputs are qualified by their strobes so the bus reads
    // zero whenever nothing is being issued, including after an abort.
    assign busy      = (state_q != ST_IDLE);
    assign rd_en     = (state_q == ST_ISSUE) && !hold && !abort;
    assign a_row     = rd_en ? i_q : '0;
    assign a_col     = rd_en ? p_q : '0;
    assign b_row     = rd_en ? p_q : '0;
    assign b_col     = rd_en ? c_q : '0;
    assign mac_en    = mac_vld;
    assign mac_first = mac_vld && mac_tag.first;
    assign mac_last  = mac_vld && mac_tag.last;
    assign c_wr_en   = c_wr_q;
    assign c_row     = c_wr_q ? c_row_q : '0;
    assign c_col     = c_wr_q ? c_col_q : '0;
    assign done      = (state_q == ST_FIN);
    assign err       = err_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//   Self-checking bench for matmul_seq_ctrl (RD_LAT = 2). A table of jobs with
//   hand-computed completion cycle and error code is run in a loop; a small
//   loop-nest model derives the expected read, MAC and write sequences.
//   Hand-written sequences cover reset, abort/start priority, hold with a
//   start while busy, and abort / reset in the middle of a large job.
//   Cycle 0 is the cycle in which start is presented.
// ----------------------------------------------------------------------------
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    localparam int RD_LAT = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             hold = 1'b0;
    logic             abort = 1'b0;
    logic [DIM_W-1:0] dim_n = '0, dim_m = '0, dim_j = '0, dim_k = '0;
    logic             busy, rd_en, mac_en, mac_first, mac_last, c_wr_en, done;
    logic [IDX_W-1:0] a_row, a_col, b_row, b_col, c_row, c_col;
    logic [1:0]       err;

    matmul_seq_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dim_n     (dim_n),
        .dim_m     (dim_m),
        .dim_j     (dim_j),
        .dim_k     (dim_k),
        .hold      (hold),
        .abort     (abort),
        .busy      (busy),
        .rd_en     (rd_en),
        .a_row     (a_row),
        .a_col     (a_col),
        .b_row     (b_row),
        .b_col     (b_col),
        .mac_en    (mac_en),
        .mac_first (mac_first),
        .mac_last  (mac_last),
        .c_wr_en   (c_wr_en),
        .c_row     (c_row),
        .c_col     (c_col),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [56:0] outs_all;
    assign outs_all = {busy, rd_en, a_row, a_col, b_row, b_col, mac_en, mac_first,
                       mac_last, c_wr_en, c_row, c_col, done, err};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    bit     mon_on = 1'b0;
    int     t0 = 0;
    int     rd_rel[$], rd_tag[$], mac_rel[$], mac_fl[$], wr_rel[$], wr_tag[$];
    int     done_cnt, done_rel, done_err, hold_viol;
    int     busy_at1, busy_post, err_post, probe_rel;
    longint probe_val;

    always @(negedge clk) begin
        int rel;
        if (mon_on) begin
            rel = cyc - t0;
            if (rd_en) begin
                rd_rel.push_back(rel);
                if (a_col != b_row) rd_tag.push_back(-1);
                else rd_tag.push_back((int'(a_row) << 16) | (int'(b_col) << 8) | int'(a_col));
                if (hold) hold_viol++;
            end
            if (mac_en) begin
                mac_rel.push_back(rel);
                mac_fl.push_back((int'(mac_first) << 1) | int'(mac_last));
            end
            if (c_wr_en) begin
                wr_rel.push_back(rel);
                wr_tag.push_back((int'(c_row) << 8) | int'(c_col));
            end
            if (rel == 1) busy_at1 = int'(busy);
            if (done_cnt != 0 && rel == done_rel + 1) begin
                busy_post = int'(busy);
                err_post  = int'(err);
            end
            if (done) begin
                done_cnt++;
                done_rel = rel;
                done_err = int'(err);
            end
            if (rel == probe_rel) probe_val = longint'(outs_all);
        end
    end

    // ---------------- job driver ----------------
    task automatic run_job(input int n, m, j, k, input int hold_lo, hold_hi,
                           input int poke_at, abort_at, rst_at, prb, budget);
        rd_rel.delete(); rd_tag.delete(); mac_rel.delete(); mac_fl.delete();
        wr_rel.delete(); wr_tag.delete();
        done_cnt = 0; done_rel = -1; done_err = -1; hold_viol = 0;
        busy_at1 = -1; busy_post = -1; err_post = -1;
        probe_rel = prb; probe_val = -1;
        @(posedge clk); #1;
        dim_n = DIM_W'(n); dim_m = DIM_W'(m); dim_j = DIM_W'(j); dim_k = DIM_W'(k);
        start = 1'b1; t0 = cyc; mon_on = 1'b1;
        for (int r = 1; r <= budget; r++) begin
            @(posedge clk); #1;
            start = (r == poke_at);
            if (r == poke_at) begin
                dim_n = 1; dim_m = 1; dim_j = 1; dim_k = 1;
            end
            hold  = (r >= hold_lo && r <= hold_hi);
            abort = (r == abort_at);
            if (r == rst_at)     reset = 1'b0;
            if (r == rst_at + 2) reset = 1'b1;
            if (done_cnt != 0 && r > done_rel + 2) break;
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0; reset = 1'b1; mon_on = 1'b0;
    endtask

    // ---------------- expected-sequence model ----------------
    task automatic verify_job(input string nm, input int n, m, k,
                              input int exp_err, exp_done);
        int bad, idx, exp_rel, lidx, p, efl;
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_done_at"}, done_rel, exp_done);
        check({nm, "_err"}, done_err, exp_err);
        check({nm, "_err_hold"}, err_post, exp_err);
        check({nm, "_busy_c1"}, busy_at1, 1);
        check({nm, "_idle_after"}, busy_post, 0);
        check({nm, "_rd_in_hold"}, hold_viol, 0);
        if (exp_err != 0) begin
            check({nm, "_rd_cnt"}, rd_rel.size(), 0);
            check({nm, "_mac_cnt"}, mac_rel.size(), 0);
            check({nm, "_wr_cnt"}, wr_rel.size(), 0);
        end else begin
            check({nm, "_rd_cnt"}, rd_rel.size(), n * k * m);
            check({nm, "_first_rd"}, (rd_rel.size() > 0) ? rd_rel[0] : -1, 2);
            bad = 0; idx = 0;
            for (int i = 0; i < n; i++)
                for (int c = 0; c < k; c++)
                    for (int pp = 0; pp < m; pp++) begin
                        if (idx >= rd_tag.size() || rd_tag[idx] != ((i << 16) | (c << 8) | pp))
                            bad++;
                        idx++;
                    end
            check({nm, "_rd_order"}, bad, 0);

            check({nm, "_mac_cnt"}, mac_rel.size(), n * k * m);
            bad = 0;
            for (int e = 0; e < mac_rel.size() && e < rd_rel.size(); e++) begin
                p   = rd_tag[e] & 255;
                efl = ((p == 0) ? 2 : 0) | ((p == m - 1) ? 1 : 0);
                if (mac_rel[e] != rd_rel[e] + RD_LAT || mac_fl[e] != efl) bad++;
            end
            check({nm, "_mac_align"}, bad, 0);

            check({nm, "_wr_cnt"}, wr_rel.size(), n * k);
            bad = 0; idx = 0;
            for (int i = 0; i < n; i++)
                for (int c = 0; c < k; c++) begin
                    lidx    = (i * k + c) * m + m - 1;
                    exp_rel = (lidx < mac_rel.size()) ? mac_rel[lidx] + 1 : -1;
                    if (idx >= wr_tag.size() || wr_tag[idx] != ((i << 8) | c) ||
                        wr_rel[idx] != exp_rel)
                        bad++;
                    idx++;
                end
            check({nm, "_wr_order"}, bad, 0);
        end
    endtask

    function automatic int count_from(input int q[$], input int from);
        int cnt = 0;
        foreach (q[x]) if (q[x] >= from) cnt++;
        return cnt;
    endfunction

    typedef struct {
        int n, m, j, k;
        int err;
        int done_at;
    } vec_t;

    vec_t vecs[12];

    // Mid-job cancel of a 256x128*128x256 job at cycle 1000: reads run on
    // cycles 2..999 (998 reads); dot product d writes at 132 + 128*d, so
    // seven writes land before the cancel.
    task automatic mid_job_cancel(input string nm, input bit use_reset);
        run_job(256, 128, 128, 256, -10, -10, -10,
                use_reset ? -10 : 1000, use_reset ? 1000 : -10,
                use_reset ? 1000 : 1001, 1060);
        check({nm, "_outs_zero"}, probe_val, 0);
        check({nm, "_no_done"}, done_cnt, 0);
        check({nm, "_rd_cnt"}, rd_rel.size(), 998);
        check({nm, "_wr_cnt"}, wr_rel.size(), 7);
        check({nm, "_late_wr"}, count_from(wr_rel, 1001), 0);
        check({nm, "_late_mac"}, count_from(mac_rel, 1001), 0);
        run_job(2, 2, 2, 2, -10, -10, -10, -10, -10, -10, 100);
        verify_job({nm, "_then_2x2"}, 2, 2, 2, 0, 13);
    endtask

    initial begin
        // Completion cycle for a legal job without hold: T = n*k*m reads on
        // cycles 2..T+1, last MAC at T+3, last write at T+4, done at T+5.
        // Error jobs finish at cycle 2 straight out of CHECK.
        vecs[0]  = '{1,   1,   1,   1,   0, 6};
        vecs[1]  = '{2,   2,   2,   2,   0, 13};
        vecs[2]  = '{100, 100, 50,  50,  3, 2};
        vecs[3]  = '{0,   0,   0,   0,   1, 2};
        vecs[4]  = '{300, 4,   4,   4,   2, 2};
        vecs[5]  = '{2,   2,   2,   0,   1, 2};
        vecs[6]  = '{0,   300, 300, 4,   1, 2};
        vecs[7]  = '{257, 1,   1,   1,   2, 2};
        vecs[8]  = '{3,   2,   3,   2,   3, 2};
        vecs[9]  = '{256, 1,   1,   1,   0, 261};
        vecs[10] = '{1,   256, 256, 1,   0, 261};
        vecs[11] = '{3,   2,   2,   4,   0, 29};

        // Reset: every output low during and right after reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset_outs", longint'(outs_all), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("post_reset_outs", longint'(outs_all), 0);

        // abort wins over a simultaneous start in IDLE.
        @(posedge clk); #1;
        dim_n = 2; dim_m = 2; dim_j = 2; dim_k = 2;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_beats_start", longint'(outs_all), 0);
        repeat (3) @(posedge clk);

        foreach (vecs[v]) begin
            run_job(vecs[v].n, vecs[v].m, vecs[v].j, vecs[v].k,
                    -10, -10, -10, -10, -10, -10, 400);
            verify_job($sformatf("v%0d", v), vecs[v].n, vecs[v].m, vecs[v].k,
                       vecs[v].err, vecs[v].done_at);
        end

        // 5x17*17x9 with hold on cycles 10..14 and a start while busy at 20:
        // 765 reads, five stalled cycles, done at 765 + 5 + 5.
        run_job(5, 17, 17, 9, 10, 14, 20, -10, -10, -10, 900);
        verify_job("hold", 5, 17, 9, 0, 775);

        mid_job_cancel("abort", 1'b0);
        mid_job_cancel("reset", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far",
                 n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
